// File: rtl/div_rr_scheduler_if.sv
// Request/result bundle between the two divider requesters and div_rr_scheduler.
// last_cycles is present only when DIV_CYCLE_COUNT_EN is defined.
interface div_rr_scheduler_if #(
    parameter int WIDTH = 4
);
    logic             start0;
    logic             ack0;
    logic [WIDTH-1:0] x0;
    logic [WIDTH-1:0] y0;
    logic             start1;
    logic             ack1;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] y1;
    logic             done0;
    logic             done1;
    logic             owner;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             qi;
    logic             qc;
    logic             qd;
`ifdef DIV_CYCLE_COUNT_EN
    logic [WIDTH:0]   last_cycles;
`endif

    modport master (
        output start0, ack0, x0, y0, start1, ack1, x1, y1,
`ifdef DIV_CYCLE_COUNT_EN
        input  last_cycles,
`endif
        input  done0, done1, owner, quotient, remainder, div_by_zero, qi, qc, qd
    );

    modport slave (
        input  start0, ack0, x0, y0, start1, ack1, x1, y1,
`ifdef DIV_CYCLE_COUNT_EN
        output last_cycles,
`endif
        output done0, done1, owner, quotient, remainder, div_by_zero, qi, qc, qd
    );
endinterface

// File: rtl/div_rr_scheduler.sv
// Round-robin sharing of one repetitive-subtraction divider between two requesters.
// Define DIV_CYCLE_COUNT_EN to add the last_cycles compute-length output.
//
// state | meaning
// S_QI  | idle, arbitrate start0/start1 each cycle
// S_QC  | one subtraction per cycle until xr < yr
// S_QD  | result valid, wait for the owner's ack
module div_rr_scheduler #(
    parameter int WIDTH = 4
) (
    input logic               board_clk,
    input logic               Reset,
    div_rr_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        S_QI = 2'd0,
        S_QC = 2'd1,
        S_QD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             grant;
    logic             winner;
    logic             sub_ok;
    logic             owner_ack;
    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic             owner_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             div_by_zero_r;

    // On a tie the requester that did not win last time gets the divider.
    always_comb begin
        grant     = (state == S_QI) && (bus.start0 || bus.start1);
        winner    = (bus.start0 && bus.start1) ? ~last_grant : bus.start1;
        sel_x     = winner ? bus.x1 : bus.x0;
        sel_y     = winner ? bus.y1 : bus.y0;
        sub_ok    = (xr >= yr);
        owner_ack = owner_r ? bus.ack1 : bus.ack0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_QI: if (grant) state_nxt = (sel_y == '0) ? S_QD : S_QC;
            S_QC: if (!sub_ok) state_nxt = S_QD;
            S_QD: if (owner_ack) state_nxt = S_QI;
            default: state_nxt = S_QI;
        endcase
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) state <= S_QI;
        else       state <= state_nxt;
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            last_grant    <= 1'b1;
            owner_r       <= 1'b0;
            xr            <= '0;
            yr            <= '0;
            quotient_r    <= '0;
            remainder_r   <= '0;
            div_by_zero_r <= 1'b0;
        end else begin
            case (state)
                S_QI: begin
                    if (grant) begin
                        owner_r    <= winner;
                        last_grant <= winner;
                        xr         <= sel_x;
                        yr         <= sel_y;
                        if (sel_y == '0) begin
                            quotient_r    <= '1;
                            remainder_r   <= sel_x;
                            div_by_zero_r <= 1'b1;
                        end else begin
                            quotient_r    <= '0;
                            remainder_r   <= '0;
                            div_by_zero_r <= 1'b0;
                        end
                    end
                end
                S_QC: begin
                    if (sub_ok) begin
                        xr         <= xr - yr;
                        quotient_r <= quotient_r + WIDTH'(1);
                    end else begin
                        remainder_r <= xr;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_CYCLE_COUNT_EN
    logic [WIDTH:0] cycle_cnt;
    logic [WIDTH:0] last_cycles_r;

    // The final compare cycle is counted too, so a normal divide reports Q + 1.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            cycle_cnt     <= '0;
            last_cycles_r <= '0;
        end else if (grant) begin
            cycle_cnt <= '0;
            if (sel_y == '0) last_cycles_r <= '0;
        end else if (state == S_QC) begin
            cycle_cnt <= cycle_cnt + (WIDTH+1)'(1);
            if (!sub_ok) last_cycles_r <= cycle_cnt + (WIDTH+1)'(1);
        end
    end

    assign bus.last_cycles = last_cycles_r;
`endif

    assign bus.qi          = (state == S_QI);
    assign bus.qc          = (state == S_QC);
    assign bus.qd          = (state == S_QD);
    assign bus.done0       = (state == S_QD) && !owner_r;
    assign bus.done1       = (state == S_QD) && owner_r;
    assign bus.owner       = owner_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = div_by_zero_r;
endmodule

// File: tb/tb_div_rr_scheduler.sv
// Self-checking bench for div_rr_scheduler: fixed vector table, reset corner case,
// and random traffic compared with a plain divide/round-robin reference model.
module tb_div_rr_scheduler;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   lg    = 1;

    div_rr_scheduler_if #(.WIDTH(W)) bus ();

    div_rr_scheduler #(.WIDTH(W)) dut (
        .board_clk (clk),
        .Reset     (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s0, s1, x0, y0, x1, y1;
        int own, q, r, dz, cyc;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) chk("onehot", int'(bus.qi) + int'(bus.qc) + int'(bus.qd), 1);

    task automatic drive(input int s0, input int s1, input int x0, input int y0,
                         input int x1, input int y1);
        bus.start0 = s0[0];
        bus.start1 = s1[0];
        bus.x0 = W'(x0);
        bus.y0 = W'(y0);
        bus.x1 = W'(x1);
        bus.y1 = W'(y1);
    endtask

    // Called at a negedge with the DUT in QI; returns at a negedge in QI.
    task automatic run_op(input int s0, input int s1, input int x0, input int y0,
                          input int x1, input int y1, input int own, input int q,
                          input int r, input int dz, input int cyc);
        int n;
        drive(s0, s1, x0, y0, x1, y1);
        @(posedge clk); @(negedge clk);
        if (s0 == 0 && s1 == 0) begin
            chk("idle_qi", int'(bus.qi), 1);
            return;
        end
        chk("grant_owner", int'(bus.owner), own);
        chk("grant_left_qi", int'(bus.qi), 0);
        drive(s0, s1, $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15));
        n = 0;
        while (bus.qc && n < 40) begin
            n++;
            @(posedge clk); @(negedge clk);
        end
        chk("qc_cycles", n, cyc);
        chk("in_qd", int'(bus.qd), 1);
        chk("quotient", int'(bus.quotient), q);
        chk("remainder", int'(bus.remainder), r);
        chk("div_by_zero", int'(bus.div_by_zero), dz);
        chk("done0", int'(bus.done0), own == 0 ? 1 : 0);
        chk("done1", int'(bus.done1), own == 1 ? 1 : 0);
`ifdef DIV_CYCLE_COUNT_EN
        chk("last_cycles", int'(bus.last_cycles), cyc);
`endif
        if (own == 0) bus.ack1 = 1'b1; else bus.ack0 = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.ack0 = 1'b0;
        bus.ack1 = 1'b0;
        chk("nonowner_ack_qd", int'(bus.qd), 1);
        chk("nonowner_ack_done", int'(own == 0 ? bus.done0 : bus.done1), 1);
        if (own == 0) bus.ack0 = 1'b1; else bus.ack1 = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("ack_to_qi", int'(bus.qi), 1);
        chk("ack_done0_low", int'(bus.done0), 0);
        chk("ack_done1_low", int'(bus.done1), 0);
        chk("quotient_held", int'(bus.quotient), q);
        chk("remainder_held", int'(bus.remainder), r);
        bus.ack0 = 1'b0;
        bus.ack1 = 1'b0;
        bus.start0 = 1'b0;
        bus.start1 = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_qi"}, int'(bus.qi), 1);
        chk({tag, "_qc"}, int'(bus.qc), 0);
        chk({tag, "_qd"}, int'(bus.qd), 0);
        chk({tag, "_done0"}, int'(bus.done0), 0);
        chk({tag, "_done1"}, int'(bus.done1), 0);
        chk({tag, "_owner"}, int'(bus.owner), 0);
        chk({tag, "_quotient"}, int'(bus.quotient), 0);
        chk({tag, "_remainder"}, int'(bus.remainder), 0);
        chk({tag, "_dbz"}, int'(bus.div_by_zero), 0);
`ifdef DIV_CYCLE_COUNT_EN
        chk({tag, "_last_cycles"}, int'(bus.last_cycles), 0);
`endif
    endtask

    initial begin
        int s0, s1, x0, y0, x1, y1, win, xv, yv, q, r, cyc;

        vecs[0] = '{1, 1, 15, 1, 9, 3,  0, 15, 0, 0, 16};
        vecs[1] = '{1, 1, 15, 1, 9, 3,  1,  3, 0, 0,  4};
        vecs[2] = '{1, 1, 15, 1, 9, 3,  0, 15, 0, 0, 16};
        vecs[3] = '{1, 0, 13, 4, 0, 0,  0,  3, 1, 0,  4};
        vecs[4] = '{0, 1,  0, 0, 7, 0,  1, 15, 7, 1,  0};
        vecs[5] = '{1, 0,  3, 5, 0, 0,  0,  0, 3, 0,  1};
        vecs[6] = '{0, 1,  0, 0, 0, 3,  1,  0, 0, 0,  1};
        vecs[7] = '{1, 1, 15, 15, 2, 1, 0,  1, 0, 0,  2};

        bus.ack0 = 1'b0;
        bus.ack1 = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("after_release");

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].s0, vecs[i].s1, vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1,
                   vecs[i].own, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].cyc);
            lg = vecs[i].own;
        end

        // Reset during the fifth compute cycle of 15/2 discards the partial result.
        drive(1, 0, 15, 2, 0, 0);
        @(posedge clk); @(negedge clk);
        repeat (4) begin @(posedge clk); @(negedge clk); end
        chk("pre_reset_qc", int'(bus.qc), 1);
        chk("pre_reset_quotient", int'(bus.quotient), 4);
        rst = 1'b1;
        #1;
        check_reset_values("mid_qc_reset");
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        lg = 1;
        @(negedge clk);
        chk("post_reset_qi", int'(bus.qi), 1);
        run_op(1, 0, 15, 2, 0, 0, 0, 7, 1, 0, 8);
        lg = 0;

        for (int k = 0; k < 40; k++) begin
            s0 = int'($urandom_range(0, 1));
            s1 = int'($urandom_range(0, 1));
            x0 = int'($urandom_range(0, 15));
            x1 = int'($urandom_range(0, 15));
            y0 = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 15));
            y1 = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 15));
            win = 0; q = 0; r = 0; cyc = 0; yv = 0;
            if (s0 != 0 || s1 != 0) begin
                win = (s0 != 0 && s1 != 0) ? 1 - lg : s1;
                lg  = win;
                xv  = (win == 1) ? x1 : x0;
                yv  = (win == 1) ? y1 : y0;
                if (yv == 0) begin
                    q = 15; r = xv; cyc = 0;
                end else begin
                    q = xv / yv; r = xv % yv; cyc = q + 1;
                end
            end
            run_op(s0, s1, x0, y0, x1, y1, win, q, r, (s0 + s1 != 0 && yv == 0) ? 1 : 0, cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
